// File: rtl/bit_byte_mem.sv
// Word- and bit-addressable data memory for the MCU51 core. Bit writes run as a
// two-edge read-modify-write that reports the previous bit; storage self-clears after reset.
module bit_byte_mem #(
  parameter int BITSEL    = 3,
  parameter int WIDTH     = 2**BITSEL,
  parameter int ADDRWIDTH = 4,
  parameter int DEPTH     = 2**ADDRWIDTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        CS,
  input  logic                        RW,
  input  logic                        MODE,
  input  logic [1:0]                  OP,
  input  logic [ADDRWIDTH+BITSEL-1:0] addr,
  input  logic [WIDTH-1:0]            din,
  output logic [WIDTH-1:0]            dout,
  output logic                        bout,
  output logic                        valid,
  output logic                        busy
);

  localparam int AW = ADDRWIDTH + BITSEL;
  localparam logic [ADDRWIDTH-1:0] LAST_WORD = ADDRWIDTH'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_RMW   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_SET   = 2'b01,
    OP_CLR   = 2'b10,
    OP_CPL   = 2'b11
  } bit_op_t;

  // Storage and registered state
  logic [WIDTH-1:0]     mem_q [DEPTH];
  state_t               state_q, state_d;
  logic [ADDRWIDTH-1:0] clr_ptr_q, clr_ptr_d;
  logic [WIDTH-1:0]     dout_q, dout_d;
  logic                 bout_q, bout_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;
  logic [WIDTH-1:0]     rmw_q, rmw_d;
  logic [ADDRWIDTH-1:0] rmw_word_q, rmw_word_d;
  logic [BITSEL-1:0]    rmw_bit_q, rmw_bit_d;
  bit_op_t              rmw_op_q, rmw_op_d;
  logic                 rmw_din_q, rmw_din_d;

  // Request decode and memory write port
  logic [ADDRWIDTH-1:0] word_sel;
  logic [BITSEL-1:0]    bit_sel;
  logic [WIDTH-1:0]     rd_word;
  logic                 mem_we;
  logic [ADDRWIDTH-1:0] mem_waddr;
  logic [WIDTH-1:0]     mem_wdata;
  logic                 new_bit;
  logic [WIDTH-1:0]     new_word;

  always_comb begin
    word_sel = MODE ? addr[AW-1:BITSEL] : addr[ADDRWIDTH-1:0];
    bit_sel  = addr[BITSEL-1:0];
    rd_word  = mem_q[word_sel];
  end

  // NOTE: every signal gets its default before the case so no path infers a latch.
  always_comb begin
    state_d    = state_q;
    clr_ptr_d  = clr_ptr_q;
    dout_d     = dout_q;
    bout_d     = bout_q;
    valid_d    = 1'b0;
    busy_d     = busy_q;
    rmw_d      = rmw_q;
    rmw_word_d = rmw_word_q;
    rmw_bit_d  = rmw_bit_q;
    rmw_op_d   = rmw_op_q;
    rmw_din_d  = rmw_din_q;
    mem_we     = 1'b0;
    mem_waddr  = clr_ptr_q;
    mem_wdata  = '0;
    new_bit    = 1'b0;
    new_word   = rmw_q;

    unique case (state_q)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_ptr_q;
        mem_wdata = '0;
        clr_ptr_d = clr_ptr_q + ADDRWIDTH'(1);
        if (clr_ptr_q == LAST_WORD) begin
          state_d   = ST_IDLE;
          busy_d    = 1'b0;
          clr_ptr_d = '0;
        end
      end

      ST_IDLE: begin
        if (!CS) begin
          if (RW) begin
            dout_d  = rd_word;
            bout_d  = MODE ? rd_word[bit_sel] : 1'b0;
            valid_d = 1'b1;
          end else if (!MODE) begin
            mem_we    = 1'b1;
            mem_waddr = word_sel;
            mem_wdata = din;
          end else begin
            rmw_d      = rd_word;
            rmw_word_d = word_sel;
            rmw_bit_d  = bit_sel;
            rmw_op_d   = bit_op_t'(OP);
            rmw_din_d  = din[0];
            busy_d     = 1'b1;
            state_d    = ST_RMW;
          end
        end
      end

      ST_RMW: begin
        unique case (rmw_op_q)
          OP_WRITE: new_bit = rmw_din_q;
          OP_SET:   new_bit = 1'b1;
          OP_CLR:   new_bit = 1'b0;
          OP_CPL:   new_bit = ~rmw_q[rmw_bit_q];
          default:  new_bit = rmw_din_q;
        endcase
        new_word[rmw_bit_q] = new_bit;
        mem_we    = 1'b1;
        mem_waddr = rmw_word_q;
        mem_wdata = new_word;
        bout_d    = rmw_q[rmw_bit_q];
        dout_d    = new_word;
        valid_d   = 1'b1;
        busy_d    = 1'b0;
        state_d   = ST_IDLE;
      end

      default: begin
        state_d   = ST_CLEAR;
        clr_ptr_d = '0;
        busy_d    = 1'b1;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_CLEAR;
      clr_ptr_q  <= '0;
      dout_q     <= '0;
      bout_q     <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b1;
      rmw_q      <= '0;
      rmw_word_q <= '0;
      rmw_bit_q  <= '0;
      rmw_op_q   <= OP_WRITE;
      rmw_din_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_ptr_q  <= clr_ptr_d;
      dout_q     <= dout_d;
      bout_q     <= bout_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      rmw_q      <= rmw_d;
      rmw_word_q <= rmw_word_d;
      rmw_bit_q  <= rmw_bit_d;
      rmw_op_q   <= rmw_op_d;
      rmw_din_q  <= rmw_din_d;
    end
  end

  // NOTE: the array has no reset term; the CLEAR state zeroes it, so it stays plain storage.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign dout  = dout_q;
  assign bout  = bout_q;
  assign valid = valid_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_bit_byte_mem.sv
// Self-checking bench for bit_byte_mem: expected read results are queued when a
// request is driven and compared by a monitor whenever valid pulses.
module tb_bit_byte_mem;

  localparam int BITSEL    = 3;
  localparam int WIDTH     = 8;
  localparam int ADDRWIDTH = 4;
  localparam int DEPTH     = 16;

  logic                        clk   = 1'b0;
  logic                        rst_n = 1'b0;
  logic                        CS    = 1'b1;
  logic                        RW    = 1'b1;
  logic                        MODE  = 1'b0;
  logic [1:0]                  OP    = 2'b00;
  logic [ADDRWIDTH+BITSEL-1:0] addr  = '0;
  logic [WIDTH-1:0]            din   = '0;
  logic [WIDTH-1:0]            dout;
  logic                        bout;
  logic                        valid;
  logic                        busy;

  int passed = 0;
  int total  = 0;
  logic [WIDTH:0] sb [$];
  logic [WIDTH:0] mon_exp;

  bit_byte_mem #(
    .BITSEL(BITSEL), .WIDTH(WIDTH), .ADDRWIDTH(ADDRWIDTH), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .CS(CS), .RW(RW), .MODE(MODE), .OP(OP),
    .addr(addr), .din(din), .dout(dout), .bout(bout), .valid(valid), .busy(busy)
  );

  always #5 clk = ~clk;

  // Scoreboard consumer: every valid pulse must match the oldest queued expectation
  always @(posedge clk) begin
    #1;
    if (rst_n && valid) begin
      total++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_valid: dout=%h bout=%b, nothing expected", dout, bout);
      end else begin
        mon_exp = sb.pop_front();
        if ({dout, bout} !== mon_exp)
          $display("FAIL readback: dout=%h bout=%b, expected dout=%h bout=%b",
                   dout, bout, mon_exp[WIDTH:1], mon_exp[0]);
        else
          passed++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic word_write(input logic [3:0] w, input logic [7:0] d);
    CS = 1'b0; RW = 1'b0; MODE = 1'b0; addr = {3'b011, w}; din = d;
    tick;
    CS = 1'b1;
    total++;
    if (valid !== 1'b0) $display("FAIL word_write_valid: valid=%b, expected 0", valid);
    else passed++;
  endtask

  task automatic word_read(input logic [3:0] w, input logic [7:0] exp_d);
    sb.push_back({exp_d, 1'b0});
    CS = 1'b0; RW = 1'b1; MODE = 1'b0; addr = {3'b101, w}; din = 8'h5A;
    tick;
    CS = 1'b1;
    total++;
    if (valid !== 1'b1) $display("FAIL word_read_valid w=%0d: valid=%b, expected 1", w, valid);
    else passed++;
  endtask

  task automatic bit_read(input logic [3:0] w, input logic [2:0] b,
                          input logic [7:0] exp_d, input logic exp_b);
    sb.push_back({exp_d, exp_b});
    CS = 1'b0; RW = 1'b1; MODE = 1'b1; addr = {w, b};
    tick;
    CS = 1'b1;
    total++;
    if (valid !== 1'b1) $display("FAIL bit_read_valid: valid=%b, expected 1", valid);
    else passed++;
  endtask

  task automatic bit_op(input logic [3:0] w, input logic [2:0] b, input logic [1:0] op,
                        input logic d0, input logic [7:0] exp_word, input logic exp_old);
    sb.push_back({exp_word, exp_old});
    CS = 1'b0; RW = 1'b0; MODE = 1'b1; OP = op; addr = {w, b}; din = {7'h55, d0};
    tick;
    CS = 1'b1;
    total++;
    if (busy !== 1'b1 || valid !== 1'b0)
      $display("FAIL bit_op_rmw_cycle op=%b: busy=%b valid=%b, expected busy=1 valid=0",
               op, busy, valid);
    else passed++;
    tick;
    total++;
    if (busy !== 1'b0 || valid !== 1'b1)
      $display("FAIL bit_op_done op=%b: busy=%b valid=%b, expected busy=0 valid=1",
               op, busy, valid);
    else passed++;
  endtask

  task automatic wait_clear(input string name);
    int n;
    n = 0;
    for (int i = 0; i < 64; i++) begin
      tick;
      n++;
      if (busy === 1'b0) break;
    end
    total++;
    if (n !== DEPTH || busy !== 1'b0)
      $display("FAIL %s: busy fell after %0d edges (busy=%b), expected %0d", name, n, busy, DEPTH);
    else passed++;
  endtask

  task automatic test_reset;
    #12;
    total++;
    if (busy !== 1'b1 || dout !== 8'h00 || bout !== 1'b0 || valid !== 1'b0)
      $display("FAIL reset_state: busy=%b dout=%h bout=%b valid=%b, expected 1/00/0/0",
               busy, dout, bout, valid);
    else passed++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_clear("clear_length");
    for (int a = 0; a < DEPTH; a++) word_read(4'(a), 8'h00);
  endtask

  task automatic test_word;
    word_write(4'd3, 8'hA5);
    word_read(4'd3, 8'hA5);
    tick;
    total++;
    if (valid !== 1'b0 || dout !== 8'hA5)
      $display("FAIL cs_idle_hold: valid=%b dout=%h, expected valid=0 dout=a5", valid, dout);
    else passed++;
  endtask

  task automatic test_bit_ops;
    bit_op(4'd3, 3'd1, 2'b01, 1'b0, 8'hA7, 1'b0);
    bit_op(4'd3, 3'd7, 2'b10, 1'b1, 8'h27, 1'b1);
    bit_op(4'd3, 3'd0, 2'b11, 1'b0, 8'h26, 1'b1);
    bit_op(4'd3, 3'd4, 2'b00, 1'b1, 8'h36, 1'b0);
    word_read(4'd3, 8'h36);
  endtask

  task automatic test_bit_read;
    word_write(4'd5, 8'h40);
    bit_read(4'd5, 3'd6, 8'h40, 1'b1);
    bit_read(4'd5, 3'd5, 8'h40, 1'b0);
  endtask

  task automatic test_back_to_back;
    word_write(4'd7, 8'h3C);
    word_write(4'd8, 8'hC3);
    word_read(4'd7, 8'h3C);
    word_read(4'd8, 8'hC3);
  endtask

  task automatic test_busy_collision;
    sb.push_back({8'h01, 1'b0});
    CS = 1'b0; RW = 1'b0; MODE = 1'b1; OP = 2'b01; addr = {4'd1, 3'd0}; din = 8'h00;
    tick;
    CS = 1'b0; RW = 1'b0; MODE = 1'b0; addr = {3'b000, 4'd2}; din = 8'hFF;
    tick;
    CS = 1'b1;
    word_read(4'd2, 8'h00);
    word_read(4'd1, 8'h01);
  endtask

  task automatic test_reset_mid_rmw;
    CS = 1'b0; RW = 1'b0; MODE = 1'b1; OP = 2'b01; addr = {4'd9, 3'd2}; din = 8'h00;
    tick;
    CS = 1'b1;
    rst_n = 1'b0;
    #1;
    total++;
    if (busy !== 1'b1 || valid !== 1'b0 || dout !== 8'h00 || bout !== 1'b0)
      $display("FAIL reset_mid_rmw_outputs: busy=%b valid=%b dout=%h bout=%b, expected 1/0/00/0",
               busy, valid, dout, bout);
    else passed++;
    tick;
    tick;
    rst_n = 1'b1;
    // Restart the clear part-way through; it must still take a full DEPTH edges
    repeat (5) tick;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    wait_clear("clear_after_restart");
    word_read(4'd9, 8'h00);
    word_read(4'd3, 8'h00);
    word_read(4'd5, 8'h00);
  endtask

  initial begin
    test_reset;
    test_word;
    test_bit_ops;
    test_bit_read;
    test_back_to_back;
    test_busy_collision;
    test_reset_mid_rmw;
    tick;
    tick;
    total++;
    if (sb.size() !== 0) $display("FAIL scoreboard_drain: %0d results missing, expected 0", sb.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
